// File: rtl/nrzi_rx_decoder.sv
// NRZI receive decoder: line-level to bit recovery, sync hunt,
// bit-unstuffing and LSB-first byte assembly behind a valid/ready register.
module nrzi_rx_decoder #(
  parameter int          DATA_W       = 8,
  parameter int          STUFF_LEN    = 6,
  parameter logic [7:0]  SYNC_PATTERN = 8'h80
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              line_in,
  input  logic              frame_end,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              frame_active,
  output logic              stuff_err,
  output logic              overrun_err
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam int OW = $clog2(STUFF_LEN + 1);

  typedef enum logic {HUNT, DATA} state_t;

  state_t            state_q, state_d;
  logic              prev_line_q, prev_line_d;
  logic [7:0]        sync_q, sync_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [OW-1:0]     ones_q, ones_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              stuff_err_q, stuff_err_d;
  logic              overrun_err_q, overrun_err_d;

  logic              dbit;
  logic              xfer;
  logic              word_done;
  logic [7:0]        sync_nxt;
  logic [DATA_W-1:0] asm_nxt;

  assign dbit     = ~(line_in ^ prev_line_q);
  assign xfer     = out_valid_q & out_ready;
  assign sync_nxt = {dbit, sync_q[7:1]};
  assign asm_nxt  = {dbit, asm_q[DATA_W-1:1]};

  always_comb begin
    state_d       = state_q;
    prev_line_d   = prev_line_q;
    sync_d        = sync_q;
    cnt_d         = cnt_q;
    ones_d        = ones_q;
    asm_d         = asm_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    stuff_err_d   = 1'b0;
    overrun_err_d = 1'b0;
    word_done     = 1'b0;

    if (bit_en) prev_line_d = line_in;

    if (frame_end) begin
      state_d = HUNT;
      sync_d  = '0;
      cnt_d   = '0;
      ones_d  = '0;
    end else if (bit_en) begin
      unique case (state_q)
        HUNT: begin
          sync_d = sync_nxt;
          if (sync_nxt == SYNC_PATTERN) begin
            state_d = DATA;
            sync_d  = '0;
            cnt_d   = '0;
            ones_d  = '0;
          end
        end
        DATA: begin
          if (ones_q == OW'(STUFF_LEN)) begin
            // after a full run of 1s the next bit must be the stuffed 0
            if (!dbit) begin
              ones_d = '0;
            end else begin
              stuff_err_d = 1'b1;
              state_d     = HUNT;
              cnt_d       = '0;
              ones_d      = '0;
            end
          end else begin
            asm_d  = asm_nxt;
            ones_d = dbit ? ones_q + 1'b1 : '0;
            if (cnt_q == CW'(DATA_W - 1)) begin
              word_done = 1'b1;
              cnt_d     = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end

    if (word_done) begin
      if (!out_valid_q || xfer) begin
        out_data_d  = asm_nxt;
        out_valid_d = 1'b1;
      end else begin
        overrun_err_d = 1'b1;
      end
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HUNT;
      prev_line_q   <= 1'b1;
      sync_q        <= '0;
      cnt_q         <= '0;
      ones_q        <= '0;
      asm_q         <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      stuff_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_line_q   <= prev_line_d;
      sync_q        <= sync_d;
      cnt_q         <= cnt_d;
      ones_q        <= ones_d;
      asm_q         <= asm_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      stuff_err_q   <= stuff_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign frame_active = (state_q == DATA);
  assign stuff_err    = stuff_err_q;
  assign overrun_err  = overrun_err_q;

endmodule
